// File: rtl/afifo_level_pkg.sv
// Shared helpers for the dual-clock level FIFO: gray/binary pointer conversion.
// Functions work on a fixed wide vector; callers zero-extend and truncate with width casts.
package afifo_level_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    function automatic int unsigned ptr_width(input int unsigned size);
        return int'($clog2(size)) + 1;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits contribute nothing, so this is correct for any narrower pointer.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = g;
        for (int unsigned i = 1; i < PTR_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_level_if.sv
// Producer/consumer bus of the dual-clock level FIFO; master = user side, slave = FIFO.
interface afifo_level_if #(
    parameter int unsigned Width = 12,
    parameter int unsigned Size  = 8
);
    localparam int unsigned LW = $clog2(Size) + 1;

    logic             r;
    logic [Width-1:0] rd;
    logic             rempty;
    logic             ralmost_empty;
    logic [LW-1:0]    rlevel;
    logic             runderflow;

    logic             w;
    logic [Width-1:0] wd;
    logic             wfull;
    logic             walmost_full;
    logic [LW-1:0]    wlevel;
    logic             woverflow;

    modport master (
        output r, w, wd,
        input  rd, rempty, ralmost_empty, rlevel, runderflow,
        input  wfull, walmost_full, wlevel, woverflow
    );

    modport slave (
        input  r, w, wd,
        output rd, rempty, ralmost_empty, rlevel, runderflow,
        output wfull, walmost_full, wlevel, woverflow
    );
endinterface

// File: rtl/afifo_level_gray_sync.sv
// Two-flop synchroniser for a registered gray pointer, with binary view of the synced value.
module afifo_level_gray_sync
    import afifo_level_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         dirclr,
    input  logic [W-1:0] gray_in,
    output logic [W-1:0] gray_out,
    output logic [W-1:0] bin_out
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge dirclr) begin
        if (dirclr) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= gray_in;
            sync_q <= meta_q;
        end
    end

    assign gray_out = sync_q;
    assign bin_out  = W'(gray2bin(PTR_MAX_W'(sync_q)));

endmodule

// File: rtl/afifo_level.sv
// Dual-clock FIFO with gray pointer crossing, per-side fill levels, threshold flags and
// sticky overflow/underflow. Head word is first-word-fall-through on rd.
module afifo_level
    import afifo_level_pkg::*;
#(
    parameter int unsigned Width  = 12,
    parameter int unsigned Size   = 8,
    parameter int unsigned AFull  = 6,
    parameter int unsigned AEmpty = 1
) (
    input  logic         rclk,
    input  logic         wclk,
    input  logic         dirclr,
    afifo_level_if.slave bus
);

    localparam int unsigned N  = $clog2(Size);
    localparam int unsigned PW = N + 1;

    logic [Width-1:0] mem [Size];

    // ---------------- write domain ----------------
    logic [1:0]    wrst_q;
    logic          wrst;
    logic [PW-1:0] wptr_q, wgray_q;
    logic [PW-1:0] wptr_next, wgray_next;
    logic [PW-1:0] rgray_sync, rbin_sync;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] wlevel_c;
    logic          wfull_q, woverflow_q;
    logic          push;

    // Async assert, sync release of the write-side reset.
    always_ff @(posedge wclk or posedge dirclr) begin
        if (dirclr) wrst_q <= 2'b11;
        else        wrst_q <= {wrst_q[0], 1'b0};
    end
    assign wrst = wrst_q[1];

    always_comb begin
        push       = bus.w & ~wfull_q;
        wptr_next  = wptr_q + PW'(push);
        wgray_next = PW'(bin2gray(PTR_MAX_W'(wptr_next)));
        full_cmp   = {~rgray_sync[N:N-1], rgray_sync[N-2:0]};
    end

    // wfull is held high through the reset tail so nothing is pushed on the releasing edge.
    always_ff @(posedge wclk or posedge dirclr) begin
        if (dirclr) begin
            wptr_q      <= '0;
            wgray_q     <= '0;
            wfull_q     <= 1'b1;
            woverflow_q <= 1'b0;
        end else if (wrst) begin
            wfull_q     <= 1'b1;
        end else begin
            wptr_q  <= wptr_next;
            wgray_q <= wgray_next;
            wfull_q <= (wgray_next == full_cmp);
            if (bus.w && wfull_q) woverflow_q <= 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (push) mem[wptr_q[N-1:0]] <= bus.wd;
    end

    assign wlevel_c         = wptr_q - rbin_sync;
    assign bus.wlevel       = wlevel_c;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = wrst | (wlevel_c >= PW'(AFull));
    assign bus.woverflow    = woverflow_q;

    // ---------------- read domain ----------------
    logic [1:0]    rrst_q;
    logic          rrst;
    logic [PW-1:0] rptr_q, rgray_q;
    logic [PW-1:0] rptr_next, rgray_next;
    logic [PW-1:0] wgray_sync, wbin_sync;
    logic [PW-1:0] rlevel_c;
    logic          rempty_q, runderflow_q;
    logic          pop;

    always_ff @(posedge rclk or posedge dirclr) begin
        if (dirclr) rrst_q <= 2'b11;
        else        rrst_q <= {rrst_q[0], 1'b0};
    end
    assign rrst = rrst_q[1];

    always_comb begin
        pop        = bus.r & ~rempty_q;
        rptr_next  = rptr_q + PW'(pop);
        rgray_next = PW'(bin2gray(PTR_MAX_W'(rptr_next)));
    end

    always_ff @(posedge rclk or posedge dirclr) begin
        if (dirclr) begin
            rptr_q       <= '0;
            rgray_q      <= '0;
            rempty_q     <= 1'b1;
            runderflow_q <= 1'b0;
        end else if (rrst) begin
            rempty_q     <= 1'b1;
        end else begin
            rptr_q   <= rptr_next;
            rgray_q  <= rgray_next;
            rempty_q <= (rgray_next == wgray_sync);
            if (bus.r && rempty_q) runderflow_q <= 1'b1;
        end
    end

    assign rlevel_c          = wbin_sync - rptr_q;
    assign bus.rd            = mem[rptr_q[N-1:0]];
    assign bus.rempty        = rempty_q;
    assign bus.rlevel        = rlevel_c;
    assign bus.ralmost_empty = rrst | (rlevel_c <= PW'(AEmpty));
    assign bus.runderflow    = runderflow_q;

    // ---------------- pointer crossings ----------------
    afifo_level_gray_sync #(.W(PW)) u_rgray_to_w (
        .clk      (wclk),
        .dirclr   (dirclr),
        .gray_in  (rgray_q),
        .gray_out (rgray_sync),
        .bin_out  (rbin_sync)
    );

    afifo_level_gray_sync #(.W(PW)) u_wgray_to_r (
        .clk      (rclk),
        .dirclr   (dirclr),
        .gray_in  (wgray_q),
        .gray_out (wgray_sync),
        .bin_out  (wbin_sync)
    );

endmodule

// File: tb/tb_afifo_level.sv
// Directed bench for afifo_level: reset, fill/drain vector tables, wrap cycles and streaming.
`timescale 1ns/1ps
module tb_afifo_level;

    typedef struct {
        logic        req;
        logic [11:0] data;
        logic        chk_data;
        logic        e_flag;
        logic [3:0]  e_level;
        logic        e_almost;
        logic        e_sticky;
    } vec_t;

    int   rhalf = 30;
    int   whalf = 42;
    logic rclk  = 1'b0;
    logic wclk  = 1'b0;
    logic dirclr;

    int total = 0;
    int bad   = 0;

    logic [11:0] sd;
    logic [11:0] re_exp;

    vec_t wv [10];
    vec_t rv [9];

    always #(rhalf) rclk = ~rclk;
    always #(whalf) wclk = ~wclk;

    afifo_level_if #(.Width(12), .Size(8)) bus ();

    afifo_level #(.Width(12), .Size(8), .AFull(6), .AEmpty(1)) dut (
        .rclk   (rclk),
        .wclk   (wclk),
        .dirclr (dirclr),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_wfull_clear(input string name, input int lim);
        int t = 0;
        while (bus.wfull && t < lim) begin @(negedge wclk); t++; end
        chk(name, 32'(bus.wfull), 32'd0);
    endtask

    task automatic wait_rlevel(input string name, input int val, input int lim);
        int t = 0;
        while (32'(bus.rlevel) != 32'(val) && t < lim) begin @(negedge rclk); t++; end
        chk(name, 32'(bus.rlevel), 32'(val));
    endtask

    task automatic do_reset();
        bus.w  = 1'b0;
        bus.r  = 1'b0;
        dirclr = 1'b1;
        #200;
        dirclr = 1'b0;
        wait_wfull_clear("reset_release_wfull", 10);
        repeat (4) @(negedge rclk);
    endtask

    task automatic push(input logic [11:0] d);
        int t = 0;
        @(negedge wclk);
        while (bus.wfull && t < 40) begin @(negedge wclk); t++; end
        if (bus.wfull) begin
            total++; bad++;
            $display("FAIL push_timeout: wfull stuck at 1 waiting to push 0x%0h", d);
        end else begin
            bus.w  = 1'b1;
            bus.wd = d;
            @(negedge wclk);
            bus.w  = 1'b0;
        end
    endtask

    task automatic pop(input string name, input logic [11:0] exp_d);
        int t = 0;
        @(negedge rclk);
        while (bus.rempty && t < 40) begin @(negedge rclk); t++; end
        if (bus.rempty) begin
            total++; bad++;
            $display("FAIL %s: rempty stuck at 1, expected word 0x%0h", name, exp_d);
        end else begin
            chk(name, 32'(bus.rd), 32'(exp_d));
            bus.r = 1'b1;
            @(negedge rclk);
            bus.r = 1'b0;
        end
    endtask

    task automatic stream(input int n, input bit stall);
        int sent = 0;
        int got  = 0;
        fork
            begin
                int g = 0;
                while (sent < n && g < n * 20) begin
                    @(negedge wclk); g++;
                    if (!bus.wfull) begin
                        bus.w = 1'b1; bus.wd = sd; sd = sd + 12'd1; sent++;
                    end else begin
                        bus.w = 1'b0;
                    end
                end
                @(negedge wclk);
                bus.w = 1'b0;
            end
            begin
                int g = 0;
                while (got < n && g < n * 40) begin
                    @(negedge rclk); g++;
                    if (!bus.rempty && (!stall || $urandom_range(0, 3) != 0)) begin
                        chk("stream_order", 32'(bus.rd), 32'(re_exp));
                        re_exp = re_exp + 12'd1; got++;
                        bus.r = 1'b1;
                    end else begin
                        bus.r = 1'b0;
                    end
                end
                @(negedge rclk);
                bus.r = 1'b0;
            end
        join
        chk("stream_sent", 32'(sent), 32'(n));
        chk("stream_got",  32'(got),  32'(n));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // {req, data, chk_data, wfull, wlevel, walmost_full, woverflow} after each wclk edge
        wv[0] = '{1'b1, 12'h000, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
        wv[1] = '{1'b1, 12'h001, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
        wv[2] = '{1'b1, 12'h002, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0};
        wv[3] = '{1'b1, 12'h003, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0};
        wv[4] = '{1'b1, 12'h004, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0};
        wv[5] = '{1'b1, 12'h005, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0};
        wv[6] = '{1'b1, 12'h006, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0};
        wv[7] = '{1'b1, 12'h007, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0};
        wv[8] = '{1'b1, 12'h008, 1'b0, 1'b1, 4'd8, 1'b1, 1'b1};
        wv[9] = '{1'b1, 12'h009, 1'b0, 1'b1, 4'd8, 1'b1, 1'b1};
        // {req, rd before pop, chk_data, rempty, rlevel, ralmost_empty, runderflow} after each rclk edge
        rv[0] = '{1'b1, 12'h000, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0};
        rv[1] = '{1'b1, 12'h001, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0};
        rv[2] = '{1'b1, 12'h002, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0};
        rv[3] = '{1'b1, 12'h003, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0};
        rv[4] = '{1'b1, 12'h004, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0};
        rv[5] = '{1'b1, 12'h005, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0};
        rv[6] = '{1'b1, 12'h006, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0};
        rv[7] = '{1'b1, 12'h007, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0};
        rv[8] = '{1'b1, 12'h000, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1};

        bus.r = 1'b0; bus.w = 1'b0; bus.wd = '0;
        sd = '0; re_exp = '0;
        dirclr = 1'b1;
        #1;
        chk("init_rempty", 32'(bus.rempty), 32'd1);
        chk("init_wfull",  32'(bus.wfull),  32'd1);
        chk("init_walmost_full", 32'(bus.walmost_full), 32'd1);
        chk("init_rlevel", 32'(bus.rlevel), 32'd0);
        #200;
        dirclr = 1'b0;
        wait_wfull_clear("init_release_wfull", 10);
        repeat (4) @(negedge rclk);

        // Reset mid-stream with three words held
        push(12'h111); push(12'h222); push(12'h333);
        wait_rlevel("mid_held_rlevel", 3, 20);
        #7;
        dirclr = 1'b1;
        #1;
        chk("mid_rst_rempty",     32'(bus.rempty),        32'd1);
        chk("mid_rst_wfull",      32'(bus.wfull),         32'd1);
        chk("mid_rst_rlevel",     32'(bus.rlevel),        32'd0);
        chk("mid_rst_wlevel",     32'(bus.wlevel),        32'd0);
        chk("mid_rst_ralmost",    32'(bus.ralmost_empty), 32'd1);
        chk("mid_rst_walmost",    32'(bus.walmost_full),  32'd1);
        chk("mid_rst_runderflow", 32'(bus.runderflow),    32'd0);
        chk("mid_rst_woverflow",  32'(bus.woverflow),     32'd0);
        #150;
        dirclr = 1'b0;
        wait_wfull_clear("mid_release_wfull", 10);
        repeat (4) @(negedge rclk);
        push(12'h000);
        wait_rlevel("mid_after_rlevel", 1, 20);
        pop("mid_after_rd", 12'h000);

        // Fill from empty with the reader idle
        do_reset();
        @(negedge wclk);
        for (int i = 0; i < 10; i++) begin
            bus.w  = wv[i].req;
            bus.wd = wv[i].data;
            @(negedge wclk);
            chk($sformatf("fill%0d_wfull", i),        32'(bus.wfull),        32'(wv[i].e_flag));
            chk($sformatf("fill%0d_wlevel", i),       32'(bus.wlevel),       32'(wv[i].e_level));
            chk($sformatf("fill%0d_walmost_full", i), 32'(bus.walmost_full), 32'(wv[i].e_almost));
            chk($sformatf("fill%0d_woverflow", i),    32'(bus.woverflow),    32'(wv[i].e_sticky));
        end
        bus.w = 1'b0;
        wait_rlevel("fill_rlevel_settle", 8, 20);
        chk("fill_rempty", 32'(bus.rempty), 32'd0);

        // Drain from full, one pop past empty
        @(negedge rclk);
        for (int i = 0; i < 9; i++) begin
            if (rv[i].chk_data) chk($sformatf("drain%0d_rd", i), 32'(bus.rd), 32'(rv[i].data));
            bus.r = rv[i].req;
            @(negedge rclk);
            chk($sformatf("drain%0d_rempty", i),     32'(bus.rempty),        32'(rv[i].e_flag));
            chk($sformatf("drain%0d_rlevel", i),     32'(bus.rlevel),        32'(rv[i].e_level));
            chk($sformatf("drain%0d_ralmost", i),    32'(bus.ralmost_empty), 32'(rv[i].e_almost));
            chk($sformatf("drain%0d_runderflow", i), 32'(bus.runderflow),    32'(rv[i].e_sticky));
        end
        bus.r = 1'b0;
        wait_wfull_clear("drain_wfull_clear", 6);
        chk("drain_woverflow_sticky", 32'(bus.woverflow), 32'd1);
        do_reset();
        chk("clr_woverflow",  32'(bus.woverflow),  32'd0);
        chk("clr_runderflow", 32'(bus.runderflow), 32'd0);

        // Three full fill/drain cycles so the pointer MSB toggles
        begin
            logic [11:0] d = 12'h100;
            for (int c = 0; c < 3; c++) begin
                for (int k = 0; k < 8; k++) push(d + 12'(k));
                chk($sformatf("wrap%0d_full", c), 32'(bus.wfull), 32'd1);
                wait_rlevel($sformatf("wrap%0d_rlevel8", c), 8, 20);
                chk($sformatf("wrap%0d_no_false_empty", c), 32'(bus.rempty), 32'd0);
                for (int k = 0; k < 8; k++) begin
                    pop($sformatf("wrap%0d_rd%0d", c, k), d + 12'(k));
                    if (c == 0 && k == 0) begin
                        int cnt = 0;
                        chk("wrap_wfull_held_after_pop", 32'(bus.wfull), 32'd1);
                        while (bus.wfull && cnt < 8) begin @(negedge wclk); cnt++; end
                        chk("wrap_wfull_release_latency", 32'(cnt <= 4), 32'd1);
                    end
                end
                chk($sformatf("wrap%0d_empty", c), 32'(bus.rempty), 32'd1);
                wait_wfull_clear($sformatf("wrap%0d_no_false_full", c), 10);
                begin
                    int t = 0;
                    while (bus.wlevel != 4'd0 && t < 10) begin @(negedge wclk); t++; end
                    chk($sformatf("wrap%0d_wlevel0", c), 32'(bus.wlevel), 32'd0);
                end
                d = d + 12'd8;
            end
        end

        // Streaming: reader faster, then slower with random stalls
        do_reset();
        sd = 12'h000; re_exp = 12'h000;
        stream(3000, 1'b0);
        rhalf = 55;
        repeat (2) @(negedge rclk);
        stream(3000, 1'b1);
        chk("stream_woverflow",  32'(bus.woverflow),  32'd0);
        chk("stream_runderflow", 32'(bus.runderflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
